// File: rtl/mem_stream_reader_pkg.sv
// rtl/mem_stream_reader_pkg.sv - shared FSM encoding and output buffer sizing for mem_stream_reader
package mem_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/mem_stream_reader_fifo2.sv
// rtl/mem_stream_reader_fifo2.sv - 2-entry registered FIFO with occupancy count
// Head entry is presented directly from storage; push and pop may coincide even when full.
module mem_stream_reader_fifo2
  import mem_stream_reader_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] entry_q [BUF_DEPTH];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = i_pop && (count_q != '0);
  assign do_push = i_push && ((count_q != CNT_W'(BUF_DEPTH)) || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      // When full, the write slot is the head being popped this same edge.
      if (do_push) begin
        entry_q[wr_ptr_q] <= i_push_data;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign o_head  = entry_q[rd_ptr_q];
  assign o_valid = (count_q != '0);
  assign o_count = count_q;

endmodule

// File: rtl/mem_stream_reader.sv
// rtl/mem_stream_reader.sv - streams len words from buffer memory port B as a valid/ready stream
// Optional MEM_STREAM_READER_STRIDE_EN adds a per-command address stride input.
module mem_stream_reader
  import mem_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_len,
`ifdef MEM_STREAM_READER_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] i_stride,
`endif
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [3:0]            o_mem_we,
  input  logic [DATA_WIDTH-1:0] i_mem_dout,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic                  o_tlast
);

  localparam logic [ADDR_WIDTH:0] REMAIN_ONE = (ADDR_WIDTH+1)'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remain_q, remain_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] step;

  logic [CNT_W-1:0]      buf_count;
  logic                  buf_valid;
  logic [DATA_WIDTH:0]   buf_head;
  logic                  pop;
  logic [CNT_W:0]        occupancy;
  logic [CNT_W:0]        credit_limit;
  logic                  credit_ok;

`ifdef MEM_STREAM_READER_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stride_q <= '0;
    end else if ((state_q == ST_IDLE) && i_start) begin
      stride_q <= i_stride;
    end
  end

  assign step = stride_q;
`else
  assign step = ADDR_WIDTH'(1);
`endif

  assign pop = buf_valid && i_tready;

  // A read may issue only if its word is guaranteed a buffer slot when it lands.
  assign occupancy    = {1'b0, buf_count} + {{CNT_W{1'b0}}, inflight_q};
  assign credit_limit = (CNT_W+1)'(BUF_DEPTH) + {{CNT_W{1'b0}}, pop};
  assign credit_ok    = (occupancy < credit_limit);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remain_d        = remain_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    done_d          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            addr_d   = i_base_addr;
            remain_d = i_len;
            state_d  = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (credit_ok) begin
          addr_d          = addr_q + step;
          remain_d        = remain_q - REMAIN_ONE;
          inflight_d      = 1'b1;
          inflight_last_d = (remain_q == REMAIN_ONE);
          if (remain_q == REMAIN_ONE) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && buf_head[DATA_WIDTH]) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  // Each word carries its own last flag so tlast follows the data through the buffer.
  mem_stream_reader_fifo2 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_out_buf (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_push      (inflight_q),
    .i_push_data ({inflight_last_q, i_mem_dout}),
    .i_pop       (pop),
    .o_head      (buf_head),
    .o_valid     (buf_valid),
    .o_count     (buf_count)
  );

  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = done_q;
  assign o_mem_addr = addr_q;
  assign o_mem_we   = 4'b0000;
  assign o_tdata    = buf_head[DATA_WIDTH-1:0];
  assign o_tlast    = buf_head[DATA_WIDTH];
  assign o_tvalid   = buf_valid;

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb/tb_mem_stream_reader.sv - randomized self-checking bench for mem_stream_reader
// Stride cases are exercised when MEM_STREAM_READER_STRIDE_EN is defined.
module tb_mem_stream_reader;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          i_clk = 1'b0;
  logic          i_rstn;
  logic          i_start;
  logic [AW-1:0] i_base_addr;
  logic [AW:0]   i_len;
`ifdef MEM_STREAM_READER_STRIDE_EN
  logic [AW-1:0] i_stride;
`endif
  logic          o_busy;
  logic          o_done;
  logic [AW-1:0] o_mem_addr;
  logic [3:0]    o_mem_we;
  logic [DW-1:0] i_mem_dout;
  logic [DW-1:0] o_tdata;
  logic          o_tvalid;
  logic          i_tready;
  logic          o_tlast;

  logic [DW-1:0] mem [DEPTH];

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) i_mem_dout <= mem[o_mem_addr];

  mem_stream_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_len       (i_len),
`ifdef MEM_STREAM_READER_STRIDE_EN
    .i_stride    (i_stride),
`endif
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_mem_addr  (o_mem_addr),
    .o_mem_we    (o_mem_we),
    .i_mem_dout  (i_mem_dout),
    .o_tdata     (o_tdata),
    .o_tvalid    (o_tvalid),
    .i_tready    (i_tready),
    .o_tlast     (o_tlast)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"},   o_busy,     0);
    check_eq({tag, "_done"},   o_done,     0);
    check_eq({tag, "_addr"},   o_mem_addr, 0);
    check_eq({tag, "_we"},     o_mem_we,   0);
    check_eq({tag, "_tdata"},  o_tdata,    0);
    check_eq({tag, "_tvalid"}, o_tvalid,   0);
    check_eq({tag, "_tlast"},  o_tlast,    0);
  endtask

  task automatic idle_check();
    @(negedge i_clk);
    check_eq("idle_done",   o_done,   0);
    check_eq("idle_busy",   o_busy,   0);
    check_eq("idle_tvalid", o_tvalid, 0);
  endtask

  // Caller must be at a negedge. mode 0: ready held high, 1: toggling, 2: random with stray starts.
  task automatic run_xfer(input int base, input int len, input int stride, input int mode);
    logic [DW:0] exp_q[$];
    logic [DW:0] exp_w;
    logic [DW-1:0] prev_data;
    logic prev_last;
    bit pending_done;
    bit seen_first;
    bit prev_stall;
    int k;
    int limit;
    for (int j = 0; j < len; j++) begin
      exp_q.push_back({(j == len - 1), mem[(base + j * stride) % DEPTH]});
    end
    i_start     = 1'b1;
    i_base_addr = AW'(base);
    i_len       = (AW+1)'(len);
`ifdef MEM_STREAM_READER_STRIDE_EN
    i_stride    = AW'(stride);
`endif
    i_tready     = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    pending_done = (len == 0);
    seen_first   = 1'b0;
    prev_stall   = 1'b0;
    prev_data    = '0;
    prev_last    = 1'b0;
    k            = 0;
    limit        = 4 * len + 40;
    forever begin
      @(negedge i_clk);
      k++;
      i_start = 1'b0;
      if (pending_done) begin
        check_eq("done_pulse",  o_done,   1);
        check_eq("done_busy",   o_busy,   0);
        check_eq("done_tvalid", o_tvalid, 0);
        if (mode == 0) check_eq("xfer_cycles", k, (len == 0) ? 1 : len + 3);
        break;
      end
      check_eq("busy", o_busy, 1);
      check_eq("no_early_done", o_done, 0);
      if (prev_stall) begin
        check_eq("stall_tvalid", o_tvalid, 1);
        check_eq("stall_tdata",  o_tdata,  prev_data);
        check_eq("stall_tlast",  o_tlast,  prev_last);
      end
      if (o_tvalid && !seen_first) begin
        seen_first = 1'b1;
        check_eq("first_latency", k - 1, 2);
      end
      case (mode)
        0:       i_tready = 1'b1;
        1:       i_tready = ~i_tready;
        default: i_tready = ($urandom_range(0, 3) != 0);
      endcase
      if (mode == 2) begin
        i_start     = ($urandom_range(0, 3) == 0);
        i_base_addr = AW'($urandom);
        i_len       = (AW+1)'($urandom_range(0, 30));
      end
      if (o_tvalid && i_tready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", o_tvalid, 0);
        end else begin
          exp_w = exp_q.pop_front();
          check_eq("tdata", o_tdata, exp_w[DW-1:0]);
          check_eq("tlast", o_tlast, exp_w[DW]);
          if (exp_q.size() == 0) pending_done = 1'b1;
        end
      end
      prev_stall = o_tvalid && !i_tready;
      prev_data  = o_tdata;
      prev_last  = o_tlast;
      if (k >= limit) begin
        check_eq("xfer_timeout", exp_q.size(), 0);
        break;
      end
    end
    i_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int beats;
    i_rstn      = 1'b0;
    i_start     = 1'b0;
    i_base_addr = '0;
    i_len       = '0;
`ifdef MEM_STREAM_READER_STRIDE_EN
    i_stride    = AW'(1);
`endif
    i_tready    = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i) * 32'h01010101;

    #3;
    check_all_zero("reset");
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    idle_check();

    run_xfer(12'h010, 4, 1, 0);
    idle_check();
    run_xfer(12'h040, 8, 1, 1);
    idle_check();
    run_xfer(12'h3FE, 4, 1, 0);
    idle_check();
    run_xfer(0, 0, 1, 0);
    run_xfer(12'h005, 3, 1, 0);
    run_xfer(12'h3FF, 1, 1, 1);

    @(negedge i_clk);
    i_start     = 1'b1;
    i_base_addr = AW'(12'h100);
    i_len       = (AW+1)'(8);
    i_tready    = 1'b1;
    beats       = 0;
    for (int c = 0; c < 30 && beats < 2; c++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      if (o_tvalid && i_tready) beats++;
    end
    check_eq("rst_beats", beats, 2);
    @(posedge i_clk);
    #2;
    i_rstn = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge i_clk);
    check_eq("midrst_hold_done", o_done, 0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(negedge i_clk);
    check_eq("post_rst_done",   o_done,   0);
    check_eq("post_rst_busy",   o_busy,   0);
    check_eq("post_rst_tvalid", o_tvalid, 0);
    run_xfer(12'h020, 2, 1, 0);

`ifdef MEM_STREAM_READER_STRIDE_EN
    idle_check();
    run_xfer(0, 3, 32, 0);
    run_xfer(12'h3F0, 5, 12'h101, 1);
`endif

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    idle_check();
    for (int t = 0; t < 16; t++) begin
      int b;
      int l;
      int s;
      b = $urandom_range(0, DEPTH - 1);
      l = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24);
      s = 1;
`ifdef MEM_STREAM_READER_STRIDE_EN
      s = $urandom_range(0, DEPTH - 1);
`endif
      run_xfer(b, l, s, 2);
      if ($urandom_range(0, 1) == 0) idle_check();
    end

    run_xfer($urandom_range(0, DEPTH - 1), DEPTH, 1, 0);
    idle_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
